// File: rtl/d_cache_ctrl_pkg.sv
// rtl/d_cache_ctrl_pkg.sv - shared constants for the data cache controller
package d_cache_ctrl_pkg;

   typedef enum logic [1:0] {
      CACHE_IDLE  = 2'd0,
      CACHE_FILL  = 2'd1,
      CACHE_WRITE = 2'd2
   } cache_state_t;

   localparam int TAG_MSB    = 15;
   localparam int TAG_LSB    = 4;
   localparam int INDEX_MSB  = 3;
   localparam int INDEX_LSB  = 2;
   localparam int OFFSET_MSB = 1;
   localparam int OFFSET_LSB = 0;

   localparam int MEMORY_LATENCY = 4;

endpackage

// File: rtl/d_cache_array.sv
// rtl/d_cache_array.sv - tag/valid/data storage with combinational lookup
module d_cache_array
   import d_cache_ctrl_pkg::*;
#(
   parameter int WORD_SIZE  = 16,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 4,
   parameter int TAG_W      = TAG_MSB - TAG_LSB + 1,
   parameter int IDX_W      = $clog2(NUM_LINES),
   parameter int OFF_W      = $clog2(LINE_WORDS)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [IDX_W-1:0]              lookup_index,
   input  logic [TAG_W-1:0]              lookup_tag,
   input  logic [OFF_W-1:0]              lookup_offset,
   output logic                          lookup_hit,
   output logic [WORD_SIZE-1:0]          lookup_word,
   input  logic                          install_en,
   input  logic [IDX_W-1:0]              install_index,
   input  logic [TAG_W-1:0]              install_tag,
   input  logic [WORD_SIZE*LINE_WORDS-1:0] install_line,
   input  logic                          update_en,
   input  logic [IDX_W-1:0]              update_index,
   input  logic [OFF_W-1:0]              update_offset,
   input  logic [WORD_SIZE-1:0]          update_word
);

   logic [NUM_LINES-1:0]            valid;
   logic [TAG_W-1:0]                tags  [NUM_LINES];
   logic [WORD_SIZE*LINE_WORDS-1:0] lines [NUM_LINES];

   always_comb begin
      lookup_hit  = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
      lookup_word = lines[lookup_index][WORD_SIZE*int'(lookup_offset) +: WORD_SIZE];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         valid <= '0;
      else if (install_en)
         valid[install_index] <= 1'b1;
   end

   // Tag and data contents survive reset; only the valid bits are cleared.
   always_ff @(posedge clk) begin
      if (install_en) begin
         tags[install_index]  <= install_tag;
         lines[install_index] <= install_line;
      end else if (update_en) begin
         lines[update_index][WORD_SIZE*int'(update_offset) +: WORD_SIZE] <= update_word;
      end
   end

endmodule

// File: rtl/d_cache_ctrl.sv
// rtl/d_cache_ctrl.sv - direct-mapped write-through no-allocate data cache controller
module d_cache_ctrl
   import d_cache_ctrl_pkg::*;
#(
   parameter int WORD_SIZE   = 16,
   parameter int LINE_WORDS  = 4,
   parameter int NUM_LINES   = 4,
   parameter int MEM_LATENCY = MEMORY_LATENCY
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            d_readC,
   input  logic                            d_writeC,
   input  logic [WORD_SIZE-1:0]            d_address,
   input  logic [WORD_SIZE-1:0]            d_wdata,
   output logic [WORD_SIZE-1:0]            d_rdata,
   output logic                            d_cache_hit,
   output logic                            d_write_done,
   input  logic                            bus_granted,
   output logic                            mem_read,
   output logic                            mem_write,
   output logic [WORD_SIZE-1:0]            mem_address,
   output logic [WORD_SIZE-1:0]            mem_wdata,
   input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata
);

   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

   cache_state_t         state, state_next;
   logic [CW-1:0]        count, count_next;
   logic [WORD_SIZE-1:0] addr_next, wdata_next;
   logic                 arr_hit;
   logic [WORD_SIZE-1:0] arr_word;
   logic                 install_en, update_en;

   d_cache_array #(
      .WORD_SIZE  (WORD_SIZE),
      .LINE_WORDS (LINE_WORDS),
      .NUM_LINES  (NUM_LINES)
   ) u_array (
      .clk           (clk),
      .reset_n       (reset_n),
      .lookup_index  (d_address[INDEX_MSB:INDEX_LSB]),
      .lookup_tag    (d_address[TAG_MSB:TAG_LSB]),
      .lookup_offset (d_address[OFFSET_MSB:OFFSET_LSB]),
      .lookup_hit    (arr_hit),
      .lookup_word   (arr_word),
      .install_en    (install_en),
      .install_index (mem_address[INDEX_MSB:INDEX_LSB]),
      .install_tag   (mem_address[TAG_MSB:TAG_LSB]),
      .install_line  (mem_rdata),
      .update_en     (update_en),
      .update_index  (d_address[INDEX_MSB:INDEX_LSB]),
      .update_offset (d_address[OFFSET_MSB:OFFSET_LSB]),
      .update_word   (d_wdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= CACHE_IDLE;
         count       <= '0;
         mem_address <= '0;
         mem_wdata   <= '0;
      end else begin
         state       <= state_next;
         count       <= count_next;
         mem_address <= addr_next;
         mem_wdata   <= wdata_next;
      end
   end

   always_comb begin
      state_next   = state;
      count_next   = count;
      addr_next    = mem_address;
      wdata_next   = mem_wdata;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      d_write_done = 1'b0;
      d_cache_hit  = 1'b0;
      install_en   = 1'b0;
      update_en    = 1'b0;
      case (state)
         CACHE_IDLE: begin
            // A simultaneous write takes priority and suppresses the read hit.
            if (d_writeC) begin
               if (!bus_granted) begin
                  state_next = CACHE_WRITE;
                  count_next = '0;
                  addr_next  = d_address;
                  wdata_next = d_wdata;
                  update_en  = arr_hit;
               end
            end else if (d_readC) begin
               if (arr_hit) begin
                  d_cache_hit = 1'b1;
               end else if (!bus_granted) begin
                  state_next = CACHE_FILL;
                  count_next = '0;
                  addr_next  = {d_address[WORD_SIZE-1:OFFSET_MSB+1], {(OFFSET_MSB+1){1'b0}}};
               end
            end
         end
         CACHE_FILL: begin
            if (!bus_granted) begin
               mem_read = 1'b1;
               if (count == LAST) begin
                  install_en = 1'b1;
                  state_next = CACHE_IDLE;
                  count_next = '0;
               end else begin
                  count_next = count + 1'b1;
               end
            end
         end
         CACHE_WRITE: begin
            if (!bus_granted) begin
               mem_write = 1'b1;
               if (count == LAST) begin
                  d_write_done = 1'b1;
                  state_next   = CACHE_IDLE;
                  count_next   = '0;
               end else begin
                  count_next = count + 1'b1;
               end
            end
         end
         default: state_next = CACHE_IDLE;
      endcase
      d_rdata = d_cache_hit ? arr_word : '0;
   end

endmodule
